// File: rtl/wm_pkg.sv
// Shared types and helpers for the washing-machine setup controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package wm_pkg;

    // Setup steps, in the order the user walks through them.
    typedef enum logic [1:0] {
        BAL   = 2'd0,
        MODE  = 2'd1,
        TIME  = 2'd2,
        READY = 2'd3
    } step_t;

    // 7-seg display codes beyond the plain digits 0-9.
    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd11;

    // Widest BCD vector the conversion helper accepts.
    localparam int BCD_MAX_DIG = 8;

    // BCD vector (digit 0 in the LSB nibble) to binary.
    function automatic logic [31:0] bcd_to_bin(input logic [4*BCD_MAX_DIG-1:0] bcd);
        logic [31:0] acc;
        acc = '0;
        for (int i = BCD_MAX_DIG - 1; i >= 0; i--) begin
            acc = acc * 32'd10 + {28'd0, bcd[4*i +: 4]};
        end
        return acc;
    endfunction

    // One-hot step indicator lamp pattern.
    function automatic logic [3:0] step_light(input step_t s);
        logic [3:0] l;
        case (s)
            BAL:     l = 4'b0001;
            MODE:    l = 4'b0010;
            TIME:    l = 4'b0100;
            default: l = 4'b1000;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_CYCLES enabled clocks.
// Latency: tick is combinational from the counter state (asserted on the wrap cycle).
// Backpressure: none; en freezes the count, clr forces it back to 0.
// Ports: clk, rst (async active-low), en (count enable), clr (sync clear), tick (wrap strobe).
module wm_tick_gen #(
    parameter int unsigned TICK_CYCLES = 66000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tick = en && !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/wm_setup_ctrl.sv
// Pre-wash setup: balance entry, mode pick, time set, funded start with go strobe.
// Latency: go and bal_after appear one cycle after the accepted start confirm.
// Backpressure: none; one-cycle button pulses are consumed the cycle they arrive.
// Ports: clk/rst (async active-low), on (freeze when low), dig_sw/sign_sw/ok_pulse/inc_pulse
// from the debounced front end; bal/mode/minutes/cost/start_ok/go/bal_after to the sequencer;
// st_light step lamps; disp_r/disp_l digit codes for the 7-seg scanners.
module wm_setup_ctrl
    import wm_pkg::*;
#(
    parameter int unsigned               NUM_DIG     = 3,
    parameter int unsigned               BAL_W       = 10,
    parameter int unsigned               NUM_MODES   = 4,
    parameter int unsigned               TICK_CYCLES = 66000000,
    parameter logic [8*NUM_MODES-1:0]    MODE_MAX    = {8'd20, 8'd15, 8'd10, 8'd30},
    parameter int unsigned               PRICE       = 2,
    localparam int                       MODE_W      = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       on,
    input  logic [NUM_DIG-1:0]         dig_sw,
    input  logic                       sign_sw,
    input  logic                       ok_pulse,
    input  logic                       inc_pulse,
    output logic [BAL_W-1:0]           bal,
    output logic [MODE_W-1:0]          mode,
    output logic [7:0]                 minutes,
    output logic [BAL_W:0]             cost,
    output logic                       start_ok,
    output logic                       go,
    output logic [BAL_W-1:0]           bal_after,
    output logic [3:0]                 st_light,
    output logic [4*(NUM_DIG+1)-1:0]   disp_r,
    output logic [15:0]                disp_l
);

    step_t                     state;
    logic [NUM_DIG-1:0][3:0]   digits;
    logic [3:0]                sign_code;
    logic [MODE_W-1:0]         cand;

    logic                      tick;
    logic                      tick_en;
    logic                      tick_clr;
    logic [4*BCD_MAX_DIG-1:0]  digs_ext;
    logic [BAL_W-1:0]          bal_bin;
    logic [7:0]                mode_max;
    logic [8:0]                min_sum;
    logic [MODE_W-1:0]         cand_nxt;
    logic                      bal_entry_ok;
    logic [7:0]                min_rem;

    // Counter only runs in BAL; holding it clear elsewhere makes every BAL entry start at 0.
    assign tick_en  = on && (state == BAL);
    assign tick_clr = on && (state != BAL);

    wm_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        digs_ext = '0;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            digs_ext[4*i +: 4] = digits[i];
        end
    end

    assign bal_bin  = BAL_W'(bcd_to_bin(digs_ext));
    assign mode_max = MODE_MAX[8*int'(mode) +: 8];
    assign min_sum  = {1'b0, minutes} + (dig_sw[0] ? 9'd10 : 9'd1);
    assign cand_nxt = (cand == MODE_W'(NUM_MODES - 1)) ? '0 : cand + 1'b1;
    assign cost     = (BAL_W+1)'(minutes) * (BAL_W+1)'(PRICE);
    assign start_ok = ((state == TIME) || (state == READY)) && (minutes != 8'd0)
                      && (cost <= {1'b0, bal});
    assign st_light = step_light(state);

    // A balance is only accepted once every switch is back down and it is not negative.
    assign bal_entry_ok = (dig_sw == '0) && !sign_sw && (sign_code != DIG_MINUS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BAL;
            digits    <= '0;
            sign_code <= 4'd0;
            cand      <= '0;
            bal       <= '0;
            mode      <= '0;
            minutes   <= '0;
            bal_after <= '0;
            go        <= 1'b0;
            disp_l    <= {4{DIG_BLANK}};
        end else if (!on) begin
            go <= 1'b0;
        end else begin
            go <= 1'b0;
            case (state)
                BAL: begin
                    // ok wins over a same-cycle tick; that tick's increments are dropped.
                    if (ok_pulse) begin
                        if (bal_entry_ok) begin
                            bal   <= bal_bin;
                            cand  <= '0;
                            state <= MODE;
                        end else begin
                            digits    <= '0;
                            sign_code <= 4'd0;
                        end
                    end else if (tick) begin
                        for (int i = 0; i < int'(NUM_DIG); i++) begin
                            if (dig_sw[i]) begin
                                digits[i] <= (digits[i] == 4'd9) ? 4'd0 : digits[i] + 4'd1;
                            end
                        end
                        if (sign_sw) begin
                            sign_code <= (sign_code == DIG_MINUS) ? 4'd0 : DIG_MINUS;
                        end
                    end
                end
                MODE: begin
                    if (ok_pulse) begin
                        mode    <= cand;
                        disp_l  <= {4'(cand), DIG_BLANK, DIG_BLANK, DIG_BLANK};
                        minutes <= '0;
                        state   <= TIME;
                    end else if (inc_pulse) begin
                        cand <= cand_nxt;
                    end
                end
                TIME: begin
                    if (ok_pulse) begin
                        if (start_ok) begin
                            state <= READY;
                        end
                    end else if (inc_pulse) begin
                        minutes <= (min_sum > {1'b0, mode_max}) ? 8'd0 : min_sum[7:0];
                    end
                end
                READY: begin
                    // cost <= bal is guaranteed by start_ok, so the low bits suffice.
                    go        <= 1'b1;
                    bal_after <= bal - cost[BAL_W-1:0];
                    bal       <= bal - cost[BAL_W-1:0];
                    digits    <= '0;
                    sign_code <= 4'd0;
                    state     <= BAL;
                end
                default: state <= BAL;
            endcase
        end
    end

    // Right display: balance digits + sign in BAL, candidate in MODE, minutes in BCD after.
    always_comb begin
        disp_r  = '0;
        min_rem = minutes;
        case (state)
            BAL: begin
                for (int i = 0; i < int'(NUM_DIG); i++) begin
                    disp_r[4*i +: 4] = digits[i];
                end
                disp_r[4*NUM_DIG +: 4] = sign_code;
            end
            MODE: begin
                disp_r[3:0] = 4'(cand);
            end
            default: begin
                for (int i = 0; i < int'(NUM_DIG); i++) begin
                    disp_r[4*i +: 4] = 4'(min_rem % 8'd10);
                    min_rem          = min_rem / 8'd10;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_wm_setup_ctrl.sv
module tb_wm_setup_ctrl;

    localparam int NUM_DIG = 3;
    localparam int BAL_W   = 10;
    localparam int MODE_W  = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      on = 1'b1;
    logic [NUM_DIG-1:0]        dig_sw = '0;
    logic                      sign_sw = 1'b0;
    logic                      ok_pulse = 1'b0;
    logic                      inc_pulse = 1'b0;
    logic [BAL_W-1:0]          bal;
    logic [MODE_W-1:0]         mode;
    logic [7:0]                minutes;
    logic [BAL_W:0]            cost;
    logic                      start_ok;
    logic                      go;
    logic [BAL_W-1:0]          bal_after;
    logic [3:0]                st_light;
    logic [4*(NUM_DIG+1)-1:0]  disp_r;
    logic [15:0]               disp_l;

    int          checks = 0;
    int          errors = 0;
    int          go_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    // Mode 0 limit 30 minutes, mode 1 limit 15, mode 2 limit 10, mode 3 limit 20.
    wm_setup_ctrl #(
        .NUM_DIG     (NUM_DIG),
        .BAL_W       (BAL_W),
        .NUM_MODES   (4),
        .TICK_CYCLES (4),
        .MODE_MAX    ({8'd20, 8'd10, 8'd15, 8'd30}),
        .PRICE       (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .on        (on),
        .dig_sw    (dig_sw),
        .sign_sw   (sign_sw),
        .ok_pulse  (ok_pulse),
        .inc_pulse (inc_pulse),
        .bal       (bal),
        .mode      (mode),
        .minutes   (minutes),
        .cost      (cost),
        .start_ok  (start_ok),
        .go        (go),
        .bal_after (bal_after),
        .st_light  (st_light),
        .disp_r    (disp_r),
        .disp_l    (disp_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ok();
        ok_pulse = 1'b1;
        cyc(1);
        ok_pulse = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        repeat (n) begin
            inc_pulse = 1'b1;
            cyc(1);
            inc_pulse = 1'b0;
        end
    endtask

    task automatic enter_bal(input logic [NUM_DIG-1:0] sw, input int n);
        dig_sw = sw;
        cyc(n);
        dig_sw = '0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    // Scoreboard side: every go strobe consumes one expected post-deduction balance.
    always @(negedge clk) begin
        if (go) begin
            go_cnt++;
            if (exp_q.size() == 0) begin
                chk("go_unexpected", 32'(go), 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                chk("bal_after", 32'(bal_after), exp_v);
            end
        end
    end

    initial begin
        #1 rst = 1'b0;
        cyc(2);
        chk("rst_light",    32'(st_light),  32'h1);
        chk("rst_bal",      32'(bal),       0);
        chk("rst_mode",     32'(mode),      0);
        chk("rst_minutes",  32'(minutes),   0);
        chk("rst_go",       32'(go),        0);
        chk("rst_bal_after",32'(bal_after), 0);
        chk("rst_disp_l",   32'(disp_l),    32'hBBBB);
        chk("rst_disp_r",   32'(disp_r),    0);
        chk("rst_start_ok", 32'(start_ok),  0);
        rst = 1'b1;
        cyc(1);

        // Negative balance is rejected and cleared.
        sign_sw = 1'b1;
        cyc(4);
        sign_sw = 1'b0;
        cyc(1);
        chk("sign_disp", 32'(disp_r), 32'hA000);
        pulse_ok();
        chk("sign_rej_light", 32'(st_light), 32'h1);
        chk("sign_rej_disp",  32'(disp_r),   0);
        chk("sign_rej_bal",   32'(bal),      0);

        // Confirm while a digit switch is still up is rejected.
        dig_sw = 3'b100;
        cyc(5);
        pulse_ok();
        chk("swup_disp",  32'(disp_r),   0);
        chk("swup_light", 32'(st_light), 32'h1);
        dig_sw = '0;
        cyc(1);

        // Balance 33: three ticks on ones and tens.
        enter_bal(3'b011, 12);
        chk("bal33_disp", 32'(disp_r), 32'h0033);
        pulse_ok();
        chk("bal33_bal",   32'(bal),      33);
        chk("bal33_light", 32'(st_light), 32'h2);

        // Candidate wraps mod 4: five presses land on 1.
        pulse_inc(5);
        chk("cand_disp", 32'(disp_r), 1);
        pulse_ok();
        chk("mode_latch",  32'(mode),     1);
        chk("mode_light",  32'(st_light), 32'h4);
        chk("mode_disp_l", 32'(disp_l),   32'h1BBB);
        chk("mode_min0",   32'(minutes),  0);

        // Mode 1 limit 15: 10, then 15, then 16 wraps to 0.
        dig_sw = 3'b001;
        pulse_inc(1);
        dig_sw = '0;
        chk("time_10",      32'(minutes), 10);
        chk("time_10_disp", 32'(disp_r),  32'h0010);
        pulse_inc(5);
        chk("time_15", 32'(minutes), 15);
        pulse_inc(1);
        chk("time_wrap", 32'(minutes), 0);

        // Funded start: bal 33, mode 0, 12 minutes costs 24.
        do_reset();
        enter_bal(3'b011, 12);
        pulse_ok();
        pulse_ok();
        chk("go_mode", 32'(mode), 0);
        dig_sw = 3'b001;
        pulse_inc(1);
        dig_sw = '0;
        pulse_inc(2);
        chk("go_minutes",  32'(minutes),  12);
        chk("go_cost",     32'(cost),     24);
        chk("go_start_ok", 32'(start_ok), 1);
        exp_q.push_back(32'd9);
        pulse_ok();
        chk("ready_light", 32'(st_light), 32'h8);
        chk("ready_go_lo", 32'(go),       0);
        cyc(1);
        chk("go_hi",       32'(go),        1);
        chk("go_light",    32'(st_light),  32'h1);
        chk("go_bal",      32'(bal),       9);
        chk("go_bal_after",32'(bal_after), 9);
        cyc(1);
        chk("go_one_cycle", 32'(go), 0);

        // Insufficient funds: bal 10, 6 minutes costs 12.
        enter_bal(3'b010, 4);
        chk("bal10_disp", 32'(disp_r), 32'h0010);
        pulse_ok();
        chk("bal10_bal", 32'(bal), 10);
        pulse_ok();
        pulse_inc(6);
        chk("poor_minutes",  32'(minutes),  6);
        chk("poor_cost",     32'(cost),     12);
        chk("poor_start_ok", 32'(start_ok), 0);
        pulse_ok();
        chk("poor_ok_ignored", 32'(st_light), 32'h4);

        // Freeze: increments while off are lost.
        on = 1'b0;
        repeat (10) begin
            inc_pulse = 1'b1;
            cyc(1);
            inc_pulse = 1'b0;
            cyc(1);
        end
        chk("freeze_minutes", 32'(minutes),  6);
        chk("freeze_light",   32'(st_light), 32'h4);
        on = 1'b1;
        cyc(1);
        chk("thaw_minutes", 32'(minutes), 6);

        // Asynchronous reset in the middle of TIME.
        #2 rst = 1'b0;
        #1;
        chk("midrst_light",   32'(st_light), 32'h1);
        chk("midrst_bal",     32'(bal),      0);
        chk("midrst_go",      32'(go),       0);
        chk("midrst_minutes", 32'(minutes),  0);
        cyc(3);
        rst = 1'b1;
        cyc(3);

        chk("go_count",    32'(go_cnt),      1);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
